tx_frame_dispatch: RTL
======================

# tx_frame_dispatch

Upstream feeder for the TX frame serial interface. Accepts frames tagged with a destination switch index from the command source. Buffers them in a FIFO and issues each one as a single-cycle one-hot `load_out` pulse with `frame_out` held stable. Enforces a minimum gap between loads so the downstream frame interface can finish serialising the previous frame.

## Interface
- `NUM_SW_INST`, 5: number of switch instances; width of `load_out`.
- `FRAME_WIDTH`, 32: frame width; passed through unmodified.
- `FIFO_DEPTH`, 8: frame buffer entries; power of two, ≥2.
- `GAP_CYCLES`, 4: idle cycles forced after each load pulse; 0 allowed.
- `DST_W`, 3: destination index width; must satisfy 2^DST_W ≥ NUM_SW_INST.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `push_valid`  in  1  upstream offers a frame.
- `push_ready`  out  1  FIFO can accept; equals !full.
- `push_dst`  in  DST_W  destination switch index.
- `push_frame`  in  FRAME_WIDTH  frame payload.
- `load_out`  out  NUM_SW_INST  one-hot load strobe, one cycle per frame.
- `frame_out`  out  FRAME_WIDTH  payload of the most recently dispatched frame.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- `drop_pulse`  out  1  one-cycle flag: popped frame had invalid destination.
- `drop_cnt`  out  8  saturating count of dropped frames.

## Operation
- **Accept:** a push occurs on a cycle with push_valid && push_ready. It stores {push_dst, push_frame} at the write pointer.
- **Pointers:** pointers wrap modulo FIFO_DEPTH. Level increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- **Full:** push_ready=0 while level==FIFO_DEPTH. Any push_valid asserted in that state is ignored, not lost; upstream must hold it.
- **Dispatch FSM states:** IDLE, LOAD, GAP.
- **IDLE:**
  - If level>0, pop the head.
  - If dst<NUM_SW_INST: register load_out=1<<dst and frame_out=frame, then go to LOAD.
  - Else: set drop_pulse=1, increment drop_cnt (saturate at 255), leave load_out and frame_out unchanged, and stay in IDLE. The next frame may be popped the following cycle.
- **LOAD:** load_out is high for exactly this cycle; it clears to 0 on exit.
  - If GAP_CYCLES>0: go to GAP and load the gap counter with GAP_CYCLES-1.
  - Else: go to IDLE.
- **GAP:** load_out=0. Decrement the counter; when it reads 0, go to IDLE.
- **frame_out** holds its value until the next valid dispatch.
- **Mid-operation reset:** reset at any point empties the FIFO and discards in-flight frames. No partial pulse is emitted.

## Timing
- **Reset values:** push_ready=1, load_out=0, frame_out=0, fifo_level=0, drop_pulse=0, drop_cnt=0, state=IDLE, pointers=0.
- **Latency:** a push into an empty FIFO at edge N makes load_out visible in cycle N+2. The FIFO write takes effect at N and is seen by IDLE in cycle N+1; the outputs are registered at edge N+1.
- **frame_out** changes on the same edge that load_out rises.
- **Throughput:** at most one load per (2+GAP_CYCLES) cycles, counting IDLE, LOAD and GAP cycles.
- **Invalid frames:** an invalid-destination frame consumes one IDLE cycle.
- **Bypass:** none; an empty FIFO never forwards push data in the same cycle.
- **Full with pending pop:** push_ready is computed from the registered level only. A pop in the current cycle does not raise push_ready until the next cycle.
- **push_ready** is a registered-level function, with no combinational path from push_valid.

## Structure
- **Shared package `tx_pkg`:** dispatch state enum {IDLE, LOAD, GAP}, the drop-counter width constant, and a clog2 helper where the tool flow lacks $clog2.
- **Sub-module `sync_fifo`:** parameterised by width and depth, with push/pop/level/full/empty. It stores DST_W+FRAME_WIDTH bits per entry.
- **Top-level contents:** FSM, gap counter, one-hot decode and drop logic.

## Test plan
- Single frame, dst=2, frame=32'hA5A5_0102, GAP_CYCLES=4, pushed at cycle 10 -> load_out=5'b00100 in cycle 12 only; frame_out=32'hA5A5_0102 from cycle 12 onward.
- Burst of 3 frames (dst 0,1,4) pushed back-to-back -> loads in cycles 12, 18, 24 (6-cycle spacing); fifo_level peaks at 3 and returns to 0.
- Fill 8 frames with dispatch stalled in GAP -> push_ready=0 at level 8. A 9th frame held on push_valid is accepted only after the first pop; no frame is lost or duplicated.
- push_dst=6 with NUM_SW_INST=5 -> no load_out; drop_pulse for one cycle; drop_cnt=1; frame_out unchanged. The following valid frame dispatches one cycle later.
- 260 invalid frames -> drop_cnt saturates at 255.
- rst_n low during GAP with 4 frames queued -> all outputs at reset values next cycle and fifo_level=0. No load_out ever fires for the discarded frames.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and constants for the TX frame dispatch path.
// Holds the dispatch state encoding, the drop-counter width and a clog2 helper.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2
  } dispatch_state_t;

  localparam int DROP_CNT_W = 8;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; the head entry is readable without a pop.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo
  import tx_pkg::*;
#(
  parameter int WIDTH   = 35,
  parameter int DEPTH   = 8,
  parameter int LEVEL_W = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_data,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic               do_push;
  logic               do_pop;

  assign full    = (level_reg == LEVEL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LEVEL_W'(1);
        2'b01:   level_reg <= level_reg - LEVEL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign level     = level_reg;

endmodule

// File: rtl/tx_frame_dispatch.sv
// Buffers destination-tagged frames and issues each as a one-hot load pulse,
// enforcing an idle gap after every load; invalid destinations are dropped and counted.
module tx_frame_dispatch
  import tx_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int DST_W       = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  logic [DST_W-1:0]                 push_dst,
  input  logic [FRAME_WIDTH-1:0]           push_frame,
  output logic [NUM_SW_INST-1:0]           load_out,
  output logic [FRAME_WIDTH-1:0]           frame_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             drop_pulse,
  output logic [7:0]                       drop_cnt
);

  localparam int ENTRY_W = DST_W + FRAME_WIDTH;
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [ENTRY_W-1:0]     head_data;
  logic [DST_W-1:0]       head_dst;
  logic [FRAME_WIDTH-1:0] head_frame;
  logic                   head_dst_ok;
  logic [NUM_SW_INST-1:0] dst_onehot;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [LEVEL_W-1:0]     level;

  dispatch_state_t        state_reg, state_next;
  logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
  logic [NUM_SW_INST-1:0] load_reg, load_next;
  logic [FRAME_WIDTH-1:0] frame_reg, frame_next;
  logic                   drop_pulse_reg, drop_pulse_next;
  logic [DROP_CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;

  sync_fifo #(
    .WIDTH   (ENTRY_W),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_valid),
    .push_data ({push_dst, push_frame}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_dst    = head_data[ENTRY_W-1 -: DST_W];
  assign head_frame  = head_data[FRAME_WIDTH-1:0];
  // Extra bit keeps the compare correct when NUM_SW_INST == 2**DST_W.
  assign head_dst_ok = ({1'b0, head_dst} < (DST_W + 1)'(NUM_SW_INST));
  assign fifo_pop    = (state_reg == IDLE) && !fifo_empty;

  for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_decode
    assign dst_onehot[gi] = (head_dst == DST_W'(gi));
  end

  always_comb begin
    state_next      = state_reg;
    gap_cnt_next    = gap_cnt_reg;
    load_next       = '0;
    frame_next      = frame_reg;
    drop_pulse_next = 1'b0;
    drop_cnt_next   = drop_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_dst_ok) begin
            load_next  = dst_onehot;
            frame_next = head_frame;
            state_next = LOAD;
          end else begin
            drop_pulse_next = 1'b1;
            if (drop_cnt_reg != '1) drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (GAP_CYCLES > 0) begin
          state_next   = GAP;
          gap_cnt_next = GAP_W'(GAP_CYCLES - 1);
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_reg == '0) state_next = IDLE;
        else                   gap_cnt_next = gap_cnt_reg - GAP_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gap_cnt_reg    <= '0;
      load_reg       <= '0;
      frame_reg      <= '0;
      drop_pulse_reg <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      gap_cnt_reg    <= gap_cnt_next;
      load_reg       <= load_next;
      frame_reg      <= frame_next;
      drop_pulse_reg <= drop_pulse_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  assign push_ready = !fifo_full;
  assign load_out   = load_reg;
  assign frame_out  = frame_reg;
  assign fifo_level = level;
  assign drop_pulse = drop_pulse_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule
